// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, sync polarity and the small types shared by
// the sync generator and the frame reader.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Both syncs are active-low in this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic fstart;
  } vid_ctl_t;

  localparam vid_ctl_t VID_CTL_IDLE = '{
    hsync:  ~SYNC_ACTIVE,
    vsync:  ~SYNC_ACTIVE,
    de:     1'b0,
    fstart: 1'b0
  };

  // True when c lies in [lo, lo+len).
  function automatic logic in_window(cnt_t c, int lo, int len);
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port and video pins of the frame reader, bundled.
interface vga_frame_reader_if #(
  parameter int AW = 17,
  parameter int DW = 16
);
  // Read request: while regread is high the buffer samples addr_out on the
  // rising edge and returns data_in one clk later; there is no backpressure.
  logic [AW-1:0] addr_out;
  logic          regread;
  logic [DW-1:0] data_in;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [DW-1:0] rgb;
  logic          frame_start;

  modport master (
    output addr_out,
    output regread,
    input  data_in,
    output hsync,
    output vsync,
    output de,
    output rgb,
    output frame_start
  );

  modport slave (
    input  addr_out,
    input  regread,
    output data_in,
    input  hsync,
    input  vsync,
    input  de,
    input  rgb,
    input  frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical raster counters with raw (undelayed) sync and active
// decode; the counters double as the debug view of raster position.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic clk,
  input  logic rst,
  output cnt_t h_cnt_o,
  output cnt_t v_cnt_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic active_o,
  output logic line_end_o,
  output logic frame_end_o
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic line_end;
  logic frame_end;

  always_comb begin
    line_end  = (h_q == cnt_t'(H_TOT - 1));
    frame_end = line_end && (v_q == cnt_t'(V_TOT - 1));
    h_d       = line_end ? '0 : h_q + cnt_t'(1);
    v_d       = v_q;
    if (frame_end) begin
      v_d = '0;
    end else if (line_end) begin
      v_d = v_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    hsync_o  = in_window(h_q, H_VIS + H_FP, H_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_o  = in_window(v_q, V_VIS + V_FP, V_SW) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    active_o = (h_q < cnt_t'(H_VIS)) && (v_q < cnt_t'(V_VIS));
  end

  assign h_cnt_o     = h_q;
  assign v_cnt_o     = v_q;
  assign line_end_o  = line_end;
  assign frame_end_o = frame_end;

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a stored image at 2x scale out of a frame buffer and drives the VGA
// pins through a 3-stage pipeline: counters -> address -> buffer -> rgb.
module vga_frame_reader
  import vga_timing_pkg::*;
#(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input logic              clk,
  input logic              rst,
  vga_frame_reader_if.master bus
);

  localparam int PIPE = 3;

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic hsync_raw;
  logic vsync_raw;
  logic active;
  logic line_end;
  logic frame_end;

  vga_sync_gen #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SW  (H_SW),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SW  (V_SW),
    .V_BP  (V_BP)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .hsync_o     (hsync_raw),
    .vsync_o     (vsync_raw),
    .active_o    (active),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          regread_q, regread_d;
  logic [DW-1:0] rgb_q, rgb_d;
  vid_ctl_t      ctl_q [PIPE];
  vid_ctl_t      ctl_d [PIPE];
  logic          odd_img_line;

  // row_base steps by one image row after every second displayed line, so the
  // address is an add, never a multiply.
  always_comb begin
    odd_img_line = v_cnt[0] && (v_cnt < cnt_t'(2 * IMG_H));
    row_base_d   = row_base_q;
    if (frame_end) begin
      row_base_d = '0;
    end else if (line_end && odd_img_line) begin
      row_base_d = row_base_q + AW'(IMG_W);
    end
  end

  always_comb begin
    regread_d = active;
    addr_d    = addr_q;
    if (active) begin
      addr_d = row_base_q + AW'(h_cnt >> 1);
    end
  end

  // ctl_q[1].de is the active flag lined up with data_in from the buffer.
  always_comb begin
    ctl_d[0] = '{
      hsync:  hsync_raw,
      vsync:  vsync_raw,
      de:     active,
      fstart: (h_cnt == '0) && (v_cnt == '0)
    };
    for (int i = 1; i < PIPE; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
    rgb_d = ctl_q[1].de ? bus.data_in : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_q <= '0;
      addr_q     <= '0;
      regread_q  <= 1'b0;
      rgb_q      <= '0;
      for (int i = 0; i < PIPE; i++) begin
        ctl_q[i] <= VID_CTL_IDLE;
      end
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      regread_q  <= regread_d;
      rgb_q      <= rgb_d;
      for (int i = 0; i < PIPE; i++) begin
        ctl_q[i] <= ctl_d[i];
      end
    end
  end

  assign bus.addr_out    = addr_q;
  assign bus.regread     = regread_q;
  assign bus.rgb         = rgb_q;
  assign bus.hsync       = ctl_q[PIPE-1].hsync;
  assign bus.vsync       = ctl_q[PIPE-1].vsync;
  assign bus.de          = ctl_q[PIPE-1].de;
  assign bus.frame_start = ctl_q[PIPE-1].fstart;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: a default-timing instance for reset and line-level checks,
// and a shrunken-raster instance for whole-frame and mid-frame-reset checks.
module tb_vga_frame_reader;

  typedef struct {
    int hvis; int hfp; int hsw; int hbp;
    int vvis; int vfp; int vsw; int vbp;
    int imgw;
  } cfg_t;

  typedef struct {
    int addr;
    bit regread;
    bit hsync;
    bit vsync;
    bit de;
    bit fs;
    int rgb;
  } exp_t;

  cfg_t cfg_f = '{640, 16, 96, 48, 480, 10, 2, 33, 320};
  cfg_t cfg_s = '{16, 2, 4, 2, 8, 2, 2, 3, 8};

  // clock / reset
  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  vga_frame_reader_if #(.AW(17), .DW(16)) bus_f ();
  vga_frame_reader_if #(.AW(8),  .DW(16)) bus_s ();

  vga_frame_reader dut_f (
    .clk (clk),
    .rst (rst_f),
    .bus (bus_f)
  );

  vga_frame_reader #(
    .AW(8), .DW(16), .IMG_W(8), .IMG_H(4),
    .H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(2),
    .V_VIS(8),  .V_FP(2), .V_SW(2), .V_BP(3)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s)
  );

  // frame buffers: 1-clk read latency, word = address
  always @(posedge clk) if (bus_f.regread) bus_f.data_in <= bus_f.addr_out[15:0];
  always @(posedge clk) if (bus_s.regread) bus_s.data_in <= 16'(bus_s.addr_out);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins after edge k since reset release (k >= 1).
  function automatic exp_t model(cfg_t c, int k);
    exp_t e;
    int htot, vtot, ftot, p, ph, pv, q, qh, qv;
    htot = c.hvis + c.hfp + c.hsw + c.hbp;
    vtot = c.vvis + c.vfp + c.vsw + c.vbp;
    ftot = htot * vtot;
    p  = (k - 1) % ftot;
    ph = p % htot;
    pv = p / htot;
    e.regread = (ph < c.hvis) && (pv < c.vvis);
    if (e.regread)        e.addr = (pv / 2) * c.imgw + ph / 2;
    else if (pv < c.vvis) e.addr = (pv / 2) * c.imgw + (c.hvis - 1) / 2;
    else                  e.addr = ((c.vvis - 1) / 2) * c.imgw + (c.hvis - 1) / 2;
    if (k < 3) begin
      e.hsync = 1'b1; e.vsync = 1'b1; e.de = 1'b0; e.fs = 1'b0; e.rgb = 0;
    end else begin
      q  = (k - 3) % ftot;
      qh = q % htot;
      qv = q / htot;
      e.de    = (qh < c.hvis) && (qv < c.vvis);
      e.hsync = !((qh >= c.hvis + c.hfp) && (qh < c.hvis + c.hfp + c.hsw));
      e.vsync = !((qv >= c.vvis + c.vfp) && (qv < c.vvis + c.vfp + c.vsw));
      e.fs    = (q == 0);
      e.rgb   = e.de ? (((qv / 2) * c.imgw + qh / 2) % 65536) : 0;
    end
    return e;
  endfunction

  function automatic logic [37:0] act_f();
    return {bus_f.addr_out, bus_f.regread, bus_f.hsync, bus_f.vsync, bus_f.de,
            bus_f.rgb, bus_f.frame_start};
  endfunction

  function automatic logic [37:0] pack_f(exp_t e);
    return {17'(e.addr), e.regread, e.hsync, e.vsync, e.de, 16'(e.rgb), e.fs};
  endfunction

  function automatic logic [28:0] act_s();
    return {bus_s.addr_out, bus_s.regread, bus_s.hsync, bus_s.vsync, bus_s.de,
            bus_s.rgb, bus_s.frame_start};
  endfunction

  function automatic logic [28:0] pack_s(exp_t e);
    return {8'(e.addr), e.regread, e.hsync, e.vsync, e.de, 16'(e.rgb), e.fs};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act_f() !== {17'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d: got %h expected %h", i, act_f(),
                 {17'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0});
      end
    end
    checks++;
    if (act_s() !== {8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs_small: got %h expected %h", act_s(),
               {8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0});
    end
  endtask

  task automatic test_line_pixels();
    exp_t e;
    logic [15:0] exp_rgb;
    int bad = 0, bad_k = 0, fs_k = -1, fs_cnt = 0, hs_low = 0, hs_first = -1;
    logic [63:0] bad_act = '0, bad_exp = '0;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2,
              16'd0, 16'd0, 16'd1, 16'd1,
              16'd320, 16'd320, 16'd321, 16'd321};
    rst_f = 1'b0;
    for (int k = 1; k <= 2403; k++) begin
      tick();
      e = model(cfg_f, k);
      if (act_f() !== pack_f(e)) begin
        bad++;
        if (bad == 1) begin bad_k = k; bad_act = 64'(act_f()); bad_exp = 64'(pack_f(e)); end
      end
      if (k == 1) begin
        checks++;
        if ({bus_f.addr_out, bus_f.regread} !== {17'd0, 1'b1}) begin
          failures++;
          $display("FAIL first_read: got addr=%0d regread=%b expected addr=0 regread=1",
                   bus_f.addr_out, bus_f.regread);
        end
      end
      if (bus_f.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_k < 0) fs_k = k;
      end
      if (k >= 3 && k < 803 && bus_f.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k - 3;
      end
      if ((k >= 3 && k < 9) || (k >= 803 && k < 807) || (k >= 1603 && k < 1607)) begin
        exp_rgb = exp_q.pop_front();
        checks++;
        if (bus_f.rgb !== exp_rgb) begin
          failures++;
          $display("FAIL rgb_seq k=%0d: got %0d expected %0d", k, bus_f.rgb, exp_rgb);
        end
      end
    end
    checks++;
    if (fs_k !== 3 || fs_cnt !== 1) begin
      failures++;
      $display("FAIL frame_start_after_release: got k=%0d count=%0d expected k=3 count=1", fs_k, fs_cnt);
    end
    checks++;
    if (hs_low !== 96 || hs_first !== 656) begin
      failures++;
      $display("FAIL hsync_line0: got low=%0d start=%0d expected low=96 start=656", hs_low, hs_first);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL line_stream: %0d bad cycles, first k=%0d got %h expected %h", bad, bad_k, bad_act, bad_exp);
    end
  endtask

  task automatic test_frame_timing();
    exp_t e;
    int bad = 0, bad_k = 0, fs_cnt = 0, fs_k0 = -1, fs_k1 = -1;
    int vs_low = 0, de_cnt = 0, rr_cnt = 0, hs_low = 0, blank_rgb = 0;
    logic [63:0] bad_act = '0, bad_exp = '0;
    logic [7:0]  last_addr = '0, f2_addr0 = '1, f2_addr2 = '0;
    logic        last_rr = 1'b0;
    logic [15:0] last_rgb = '0;
    rst_s = 1'b1;
    tick();
    tick();
    rst_s = 1'b0;
    for (int k = 1; k <= 723; k++) begin
      tick();
      e = model(cfg_s, k);
      if (act_s() !== pack_s(e)) begin
        bad++;
        if (bad == 1) begin bad_k = k; bad_act = 64'(act_s()); bad_exp = 64'(pack_s(e)); end
      end
      if (bus_s.frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_k0 < 0) fs_k0 = k;
        else if (fs_k1 < 0) fs_k1 = k;
      end
      if (k >= 3 && k < 363) begin
        if (bus_s.vsync === 1'b0) vs_low++;
        if (bus_s.de === 1'b1) de_cnt++;
        if (bus_s.de !== 1'b1 && bus_s.rgb !== 16'd0) blank_rgb++;
      end
      if (k < 361 && bus_s.regread === 1'b1) rr_cnt++;
      if (k >= 3 && k < 27 && bus_s.hsync === 1'b0) hs_low++;
      if (k == 184) begin last_addr = bus_s.addr_out; last_rr = bus_s.regread; end
      if (k == 186) last_rgb = bus_s.rgb;
      if (k == 361) f2_addr0 = bus_s.addr_out;
      if (k == 409) f2_addr2 = bus_s.addr_out;
    end
    checks++;
    if (fs_k0 !== 3 || fs_k1 - fs_k0 !== 360 || fs_cnt !== 3) begin
      failures++;
      $display("FAIL frame_period: got first=%0d second=%0d count=%0d expected 3 363 3", fs_k0, fs_k1, fs_cnt);
    end
    checks++;
    if (vs_low !== 48) begin
      failures++;
      $display("FAIL vsync_width: got %0d expected 48", vs_low);
    end
    checks++;
    if (de_cnt !== 128 || rr_cnt !== 128) begin
      failures++;
      $display("FAIL active_count: got de=%0d regread=%0d expected 128 128", de_cnt, rr_cnt);
    end
    checks++;
    if (hs_low !== 4) begin
      failures++;
      $display("FAIL hsync_width_small: got %0d expected 4", hs_low);
    end
    checks++;
    if (blank_rgb !== 0) begin
      failures++;
      $display("FAIL blank_rgb: got %0d nonzero blanking pixels expected 0", blank_rgb);
    end
    checks++;
    if ({last_addr, last_rr, last_rgb} !== {8'd31, 1'b1, 16'd31}) begin
      failures++;
      $display("FAIL last_pixel: got addr=%0d rr=%b rgb=%0d expected 31 1 31", last_addr, last_rr, last_rgb);
    end
    checks++;
    if (f2_addr0 !== 8'd0 || f2_addr2 !== 8'd8) begin
      failures++;
      $display("FAIL row_base_wrap: got %0d/%0d expected 0/8", f2_addr0, f2_addr2);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL frame_stream: %0d bad cycles, first k=%0d got %h expected %h", bad, bad_k, bad_act, bad_exp);
    end
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    int bad_a = 0, bad_b = 0, bad_k = 0, fs_k = -1;
    logic [63:0] bad_act = '0, bad_exp = '0;
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick();
      e = model(cfg_s, k);
      if (act_s() !== pack_s(e)) bad_a++;
    end
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    checks++;
    if (act_s() !== {8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h expected %h", act_s(),
               {8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0});
    end
    for (int k = 1; k <= 400; k++) begin
      tick();
      e = model(cfg_s, k);
      if (act_s() !== pack_s(e)) begin
        bad_b++;
        if (bad_b == 1) begin bad_k = k; bad_act = 64'(act_s()); bad_exp = 64'(pack_s(e)); end
      end
      if (bus_s.frame_start === 1'b1 && fs_k < 0) fs_k = k;
    end
    checks++;
    if (bad_a !== 0) begin
      failures++;
      $display("FAIL pre_reset_stream: got %0d bad cycles expected 0", bad_a);
    end
    checks++;
    if (fs_k !== 3) begin
      failures++;
      $display("FAIL restart_frame_start: got k=%0d expected 3", fs_k);
    end
    checks++;
    if (bad_b !== 0) begin
      failures++;
      $display("FAIL restart_stream: %0d bad cycles, first k=%0d got %h expected %h", bad_b, bad_k, bad_act, bad_exp);
    end
  endtask

  initial begin
    test_reset();
    test_line_pixels();
    test_frame_timing();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
